// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART memory-mapped IO block and its byte FIFOs.
// Holds the IO address map and the status word bit layout read at UART_CTRL.
package uart_tx_fifo_pkg;

  localparam int DW = 8;

  localparam logic [31:0] UART_CTRL = 32'h8000_0000;
  localparam logic [31:0] UART_RX   = 32'h8000_0004;
  localparam logic [31:0] UART_TX   = 32'h8000_0008;

  // Status word at UART_CTRL
  localparam int STAT_TX_READY     = 0;
  localparam int STAT_RX_VALID     = 1;
  localparam int STAT_TX_OVERFLOW  = 2;
  localparam int STAT_TX_COUNT_LSB = 4;
  localparam int STAT_TX_COUNT_MSB = 11;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO with valid/ready on both sides, occupancy count and sticky overflow.
// Data-agnostic so the same block can later buffer the RX direction.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   count,
  output logic          overflow
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          drop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr[AW-1:0]];
  assign count     = wr_ptr - rd_ptr;

  assign push = in_valid && !full && !clr;
  assign pop  = !empty && out_ready && !clr;
  assign drop = in_valid && full && !clr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (drop) overflow <= 1'b1;
    end
  end

  // Storage is intentionally not reset; out_data is only meaningful with out_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] count;
  logic       overflow;

  int n_cmp = 0;
  int n_bad = 0;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of bytes plus a sticky flag.
  logic [7:0] mq[$];
  logic [7:0] popped[$];
  logic       m_ovf;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_ovf = 1'b0;
    end else if (clr) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      automatic bit was_full = (mq.size() == DEPTH);
      automatic bit do_pop   = (mq.size() > 0) && out_ready;
      if (in_valid && was_full) m_ovf = 1'b1;
      if (do_pop) popped.push_back(mq.pop_front());
      if (in_valid && !was_full) mq.push_back(in_data);
    end
  end

  always @(negedge clk) begin
    check("count", 32'(count), 32'(mq.size()));
    check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    check("in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
    check("overflow", 32'(overflow), 32'(m_ovf));
    if (mq.size() != 0) check("out_data", 32'(out_data), 32'(mq[0]));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0;

    // Reset then idle
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    cyc(); cyc();
    @(negedge clk); #1;
    check("idle_count", 32'(count), 32'd0);
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_overflow", 32'(overflow), 32'd0);

    // Single byte
    cyc();
    in_data = 8'h41; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    @(negedge clk); #1;
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data", 32'(out_data), 32'h41);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    @(negedge clk); #1;
    check("single_count_after", 32'(count), 32'd0);
    check("single_valid_after", 32'(out_valid), 32'd0);

    // Fill and overflow
    cyc();
    for (int i = 0; i < DEPTH; i++) begin
      in_data = 8'(i); in_valid = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
    @(negedge clk); #1;
    check("fill_count", 32'(count), 32'd16);
    check("fill_in_ready", 32'(in_ready), 32'd0);
    cyc();
    in_data = 8'hAA; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    @(negedge clk); #1;
    check("drop_overflow", 32'(overflow), 32'd1);
    check("drop_count", 32'(count), 32'd16);
    cyc();
    popped.delete();
    out_ready = 1'b1;
    repeat (DEPTH) cyc();
    out_ready = 1'b0;
    cyc();
    check("drain_len", 32'(popped.size()), 32'd16);
    for (int i = 0; i < popped.size() && i < DEPTH; i++)
      check("drain_byte", 32'(popped[i]), 32'(i));
    check("drain_empty", 32'(count), 32'd0);

    clr = 1'b1;
    cyc();
    clr = 1'b0;
    @(negedge clk); #1;
    check("clr_overflow", 32'(overflow), 32'd0);

    // Wrap-around with concurrent traffic: net +1 per two cycles, fills at cycle 29
    cyc();
    popped.delete();
    for (int k = 0; k < 40; k++) begin
      in_data = 8'(8'h80 + k); in_valid = 1'b1; out_ready = (k % 2 == 0);
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk); #1;
    check("wrap_count", 32'(count), 32'd16);
    check("wrap_overflow", 32'(overflow), 32'd1);
    check("wrap_popped", 32'(popped.size()), 32'd19);
    for (int i = 0; i < popped.size(); i++)
      check("wrap_order", 32'(popped[i]), 32'(8'h80 + i));

    // Full with simultaneous push and pop: pop happens, push dropped
    cyc();
    in_data = 8'hC3; in_valid = 1'b1; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk); #1;
    check("full_pp_count", 32'(count), 32'd15);
    check("full_pp_overflow", 32'(overflow), 32'd1);

    // Drain down to empty, bounded
    begin
      int budget;
      budget = 0;
      cyc();
      out_ready = 1'b1;
      while (count != 0 && budget < 40) begin
        cyc();
        budget++;
      end
      out_ready = 1'b0;
      check("drain_timeout", 32'(budget < 40), 32'd1);
    end

    // Count=1 with simultaneous push and pop
    cyc();
    in_data = 8'h55; in_valid = 1'b1;
    cyc();
    in_data = 8'h66; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk); #1;
    check("one_pp_count", 32'(count), 32'd1);
    check("one_pp_data", 32'(out_data), 32'h66);

    // clr with a concurrent push at count=5, overflow=1
    cyc();
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(8'h10 + i); in_valid = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
    @(negedge clk); #1;
    check("pre_clr_count", 32'(count), 32'd5);
    check("pre_clr_overflow", 32'(overflow), 32'd1);
    cyc();
    clr = 1'b1; in_data = 8'hEE; in_valid = 1'b1;
    cyc();
    clr = 1'b0; in_valid = 1'b0;
    @(negedge clk); #1;
    check("clr_count", 32'(count), 32'd0);
    check("clr_overflow2", 32'(overflow), 32'd0);
    check("clr_valid", 32'(out_valid), 32'd0);

    // Refill to 3, then async reset between edges
    cyc();
    for (int i = 0; i < 3; i++) begin
      in_data = 8'(8'h20 + i); in_valid = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
    @(negedge clk); #1;
    check("refill_count", 32'(count), 32'd3);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    check("async_count", 32'(count), 32'd0);
    check("async_valid", 32'(out_valid), 32'd0);
    cyc();
    rst = 1'b1;
    cyc();
    @(negedge clk); #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte FIFO between the memory-mapped IO store decode (store to 0x8000_0008) and the on-chip UART transmitter's data_in/data_in_valid/data_in_ready port.
- Lets the CPU issue back-to-back UART stores without polling tx-ready per byte.
- Exposes occupancy and a sticky overflow flag for status readback at 0x8000_0000.
- Bytes drain to the UART in order, one per accepted handshake.

Parameters:
- DEPTH, 16, entries; power of two, >= 2.
- AW, $clog2(DEPTH), pointer index width; derived, not overridden.

Ports:
- clk  input  1  core clock.
- rst  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous flush of contents and overflow flag.
- in_data  input  8  byte from store path.
- in_valid  input  1  store strobe; one byte per high cycle.
- in_ready  output  1  FIFO not full.
- out_data  output  8  head byte, to UART data_in.
- out_valid  output  1  FIFO not empty, to UART data_in_valid.
- out_ready  input  1  UART data_in_ready.
- count  output  AW+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; set when a byte is dropped.

Behaviour:
- Storage: DEPTH x 8 register array, write pointer and read pointer each AW+1 bits.
  - MSB is the wrap bit.
  - empty = pointers equal.
  - full = index bits equal and wrap bits differ.
- Reset (rst low, async): both pointers 0, count 0, overflow 0, so out_valid 0 and in_ready 1. Array contents are not reset. out_data is don't-care while out_valid is 0.
- Push: in_valid && !full.
  - Writes mem[wr_ptr[AW-1:0]] and increments wr_ptr at the clock edge.
  - Pointer wraps modulo 2*DEPTH.
- Pop: out_valid && out_ready.
  - Increments rd_ptr at the clock edge.
- Outputs: out_data = mem[rd_ptr[AW-1:0]], combinational read of the array.
- Latency: a byte pushed at edge N is visible with out_valid=1 from after edge N, i.e. the next cycle. There is no fall-through in the same cycle.
- in_ready = !full and out_valid = !empty. Both are decoded from registered pointers only, with no combinational path from in_valid or out_ready.
- Simultaneous push and pop, not full and not empty: both happen and count is unchanged.
- Push while full: byte dropped, overflow set to 1 at that edge.
  - This holds even if a pop occurs in the same cycle, because in_ready is registered-state based.
  - The pop still happens, so count becomes DEPTH-1.
- Pop while empty: impossible, since out_valid is 0. out_ready is ignored.
- count = wr_ptr - rd_ptr, modulo 2^(AW+1). It may be registered or derived, but must be consistent with the pointers every cycle.
- overflow: stays 1 until clr or reset.
- clr (synchronous, highest priority after reset):
  - Next edge sets pointers to 0 and overflow to 0.
  - Any push or pop in the same cycle is discarded and does not set overflow.
- Reset asserted mid-transfer: FIFO empties immediately (async). The UART sees out_valid fall without handshake. This is acceptable because the UART is reset by the same signal.

Decomposition:
- Shared package/header holds:
  - IO address constants: UART_CTRL 0x8000_0000, UART_RX 0x8000_0004, UART_TX 0x8000_0008.
  - Status bit positions: [0] tx_ready, [1] rx_valid, new [2] tx_overflow, [11:4] tx_count.
- No sub-module needed; the array and pointer logic live in one module.
- An RX-side instance of the same module is expected later, so keep it data-agnostic (8-bit only, no UART knowledge).

Test Plan:
- Reset then idle:
  - rst low 3 cycles, release, then hold in_valid=0.
  - Expect count=0, out_valid=0, in_ready=1, overflow=0.
- Single byte:
  - Push 0x41 with out_ready=0, then raise out_ready.
  - Expect out_valid=1 and out_data=0x41 the cycle after the push.
  - One pop, then count=0 and out_valid=0.
- Fill and overflow (DEPTH=16):
  - Push 0x00..0x0F with out_ready=0. Expect count=16 and in_ready=0.
  - Push 0xAA. Expect it dropped, overflow=1, count=16.
  - Drain. Expect exactly 0x00..0x0F in order; 0xAA never appears.
- Wrap-around with concurrent traffic:
  - Run 40 cycles of in_valid=1 with incrementing data, while out_ready toggles 1,0,1,0.
  - Expect in-order output with no loss or duplication across pointer wrap.
  - Expect count never above 16; overflow=0 unless full was reached.
- Simultaneous push/pop at boundaries:
  - At count=16, in_valid=1 and out_ready=1 in the same cycle. Expect count=15, overflow=1, head advanced.
  - At count=1, push and pop together. Expect count=1, out_data equal to the new byte.
- clr and async reset mid-operation:
  - With count=5 and overflow=1, pulse clr together with in_valid=1. Expect count=0, overflow=0, and the byte discarded.
  - Refill to 3, assert rst between edges. Expect count=0 and out_valid=0 immediately, without waiting for a clock edge.
